shift8_tx_ctrl: RTL
===================

Name: shift8_tx_ctrl

Overview:
Upstream sequencer for the team's 8-bit left shift register (parallel load, shift-left with LSB insert). It accepts bytes over a valid/ready handshake, drives the register's load/shift/in/LSB inputs, and takes the register's MSB back as an MSB-first serial stream. Each bit is held for a programmable number of clocks. It also provides frame-enable and done indications.

Parameters:
DIV, 4, clocks per serial bit (legal range 1..256)
FILL_BIT, 0, constant driven on sr_inlsb (value shifted into the register's LSB)
IDLE_LEVEL, 1, ser_out level when not transmitting

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
tx_data  input  8  byte to send, sampled only on handshake
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a byte
sr_in  output  8  parallel data to the shift register's in
sr_load  output  1  shift register load strobe
sr_shift  output  1  shift register shift strobe
sr_inlsb  output  1  shift register inLSB
sr_msb  input  1  shift register out[7]
ser_out  output  1  serial data
ser_en  output  1  high while a frame is on ser_out
done  output  1  one-cycle pulse on the last cycle of a frame

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE. Bit counter and divider counter clear to 0. Hold register clears to 0x00.
  - sr_load, sr_shift, done and ser_en all go to 0. ser_out goes to IDLE_LEVEL.
  - Reset aborts any frame in progress at that edge. No partial strobes follow.
- tx_ready = 1 exactly when the state is IDLE. It is registered state, not combinational from tx_valid.
- States: IDLE -> LOAD -> SHIFT -> IDLE.
- IDLE:
  - On an edge with tx_valid && tx_ready, capture tx_data into the hold register and go to LOAD.
  - tx_valid while not ready is ignored; no queueing.
- LOAD (exactly 1 cycle):
  - sr_load = 1 and sr_in = hold register.
  - Next state is SHIFT, with bit counter = 0 and divider = 0.
- SHIFT:
  - ser_en = 1 and ser_out = sr_msb (combinational pass-through).
  - The divider counts 0..DIV-1.
  - On the cycle with divider == DIV-1:
    - If bit counter < 7: sr_shift = 1, bit counter increments, divider wraps to 0.
    - If bit counter == 7: done = 1, sr_shift = 0, next state is IDLE.
- Outside SHIFT: ser_en = 0 and ser_out = IDLE_LEVEL.
- sr_shift is only ever asserted in SHIFT, and never together with sr_load.
- sr_in is held at the hold register value at all times. It is only meaningful while sr_load is high.
- sr_inlsb = FILL_BIT at all times.
- Timing, with the handshake edge at T0:
  - sr_load is high in cycle T0+1.
  - Bit i (MSB first, i = 0..7) is on ser_out during cycles T0+2+i*DIV .. T0+1+(i+1)*DIV.
  - sr_shift pulses on the last cycle of bits 0..6, giving 7 pulses per frame.
  - done is high in cycle T0+1+8*DIV.
  - tx_ready is high again at T0+2+8*DIV.
  - Frame-to-frame period with tx_valid held high is 8*DIV+2 cycles.
- DIV=1: sr_shift is high on every SHIFT cycle except the 8th. done is high in the 8th.
- Divider width is clog2(DIV) bits, minimum 1. Bit counter is 3 bits, with no wrap beyond 7.

Test Plan:
1. DIV=4, reset released, tx_valid=1 with tx_data=0xA5 at T0 (bench instantiates the team's 8-bit left shift register wired to the sr_* ports).
   - sr_load only at T0+1.
   - ser_out = 1,0,1,0,0,1,0,1, each bit held 4 cycles, from T0+2.
   - 7 sr_shift pulses at T0+5, 9, …, 29.
   - done at T0+33; tx_ready back high at T0+34.
2. Back-to-back frames: tx_valid held high, 0x80 then 0x01.
   - Second sr_load is 34 cycles after the first.
   - ser_out shows 1 then seven 0s, then seven 0s then 1.
   - ser_en is low for exactly 2 cycles between the frames.
3. Busy rejection: pulse tx_valid with 0xFF mid-frame while sending 0x00.
   - The pulse is ignored; ser_out stays 0 for all 8 bits.
   - No extra sr_load occurs.
4. Reset mid-frame: assert rst_n=0 during bit 3 of 0xC3.
   - At the next edge: ser_en=0, ser_out=1, tx_ready=1.
   - No further sr_shift or done.
   - A new 0x3C then transmits correctly.
5. DIV=1, send 0x96.
   - ser_out = 1,0,0,1,0,1,1,0 on consecutive cycles.
   - sr_shift high for 7 consecutive cycles; done on the 8th.
   - Total 10 cycles handshake-to-ready.
6. FILL_BIT=1 check: after frame 0x00 completes, the shift register holds 0x7F (seven 1s shifted in) and sr_inlsb is constantly 1.

Source files
------------

// File: rtl/shift8_tx_ctrl.sv
// Byte sequencer for an external 8-bit left shift register.
// Loads one byte and then streams it out MSB first, holding each bit for DIV clocks.
module shift8_tx_ctrl #(
    parameter int DIV        = 4,
    parameter bit FILL_BIT   = 1'b0,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] sr_in,
    output logic       sr_load,
    output logic       sr_shift,
    output logic       sr_inlsb,
    input  logic       sr_msb,
    output logic       ser_out,
    output logic       ser_en,
    output logic       done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic [7:0]      hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bit_q   <= 3'd0;
            div_q   <= '0;
            hold_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        div_d    = div_q;
        hold_d   = hold_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        done     = 1'b0;
        ser_en   = 1'b0;
        ser_out  = IDLE_LEVEL;
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    hold_d  = tx_data;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sr_load = 1'b1;
                bit_d   = 3'd0;
                div_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                ser_en  = 1'b1;
                ser_out = sr_msb;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    // The 8th bit is already on the MSB, so it ends the frame instead of shifting.
                    if (bit_q != 3'd7) begin
                        sr_shift = 1'b1;
                        bit_d    = bit_q + 3'd1;
                    end else begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_ready = (state_q == S_IDLE);
    assign sr_in    = hold_q;
    assign sr_inlsb = FILL_BIT;

endmodule
